// File: rtl/shift_stage.sv
// Two-stage elastic shift pipeline: S1 holds the operand, S2 holds the shift result and its zero flag.
// Both stages advance whenever the stage downstream of them is empty or draining.
module shift_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [4:0]   in_shamt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero,
  output logic         busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_PASS = 2'b10;

  logic         s1_valid_reg;
  logic [N-1:0] s1_data_reg;
  logic [4:0]   s1_shamt_reg;
  logic [1:0]   s1_op_reg;
  logic         s2_valid_reg;
  logic [N-1:0] s2_data_reg;
  logic         s2_zero_reg;

  logic         s1_adv;
  logic         s2_adv;
  logic         fill;
  logic [N-1:0] rev_in;
  logic [N-1:0] rev_out;
  logic [N-1:0] pre_shift;
  logic [N-1:0] shift_result;
  logic [5:0][N-1:0] stage_w;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign out_zero  = s2_zero_reg;
  assign busy      = s1_valid_reg || s2_valid_reg;

  // Left shifts reuse the right shifter by bit-reversing the operand and the result.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rev
      assign rev_in[gi]  = s1_data_reg[N-1-gi];
      assign rev_out[gi] = stage_w[5][N-1-gi];
    end
  endgenerate

  assign fill       = (s1_op_reg == OP_SRA) ? s1_data_reg[N-1] : 1'b0;
  assign pre_shift  = (s1_op_reg == OP_SLL) ? rev_in : s1_data_reg;
  assign stage_w[0] = pre_shift;

  // Logarithmic right shifter: stage gi shifts by 2**gi when shamt bit gi is set.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_barrel
      localparam int SH = 1 << gi;
      assign stage_w[gi+1] = s1_shamt_reg[gi] ? {{SH{fill}}, stage_w[gi][N-1:SH]}
                                              : stage_w[gi];
    end
  endgenerate

  always_comb begin
    shift_result = stage_w[5];
    if (s1_op_reg == OP_SLL) begin
      shift_result = rev_out;
    end else if (s1_op_reg == OP_PASS) begin
      shift_result = s1_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_shamt_reg <= '0;
      s1_op_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_zero_reg  <= 1'b1;
    end else begin
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        s2_data_reg  <= shift_result;
        s2_zero_reg  <= (shift_result == '0);
      end
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        s1_data_reg  <= in_data;
        s1_shamt_reg <= in_shamt;
        s1_op_reg    <= in_op;
      end
    end
  end

endmodule

// File: tb/tb_shift_stage.sv
// Bench for shift_stage: directed scenarios plus random traffic scored against an
// arithmetic shift model and an in-order queue of accepted requests.
module tb_shift_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        gotz_q[$];

  always #5 clk = ~clk;

  shift_stage #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .busy(busy)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return sd >>> s;
      default: return d;
    endcase
  endfunction

  // One clock: note which handshakes complete on the coming edge, then move to the next falling edge.
  task automatic step();
    #1;
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_data, in_shamt, in_op));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        gotz_q.push_back(out_zero);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && busy; i++) step();
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    gotz_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 32'hDEADBEEF; in_shamt = 5'd3; in_op = 2'b01;
    @(negedge clk);
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %b expected 1", out_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got valid=%b busy=%b expected 0/0", out_valid, busy); end
    $display("reset: done");
    clear_queues();
  endtask

  task automatic test_sll_latency();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h00000001; in_shamt = 5'd31; in_op = 2'b00;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_early_valid: got %b expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sll_latency_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 32'h80000000) begin n_fail++; $display("FAIL sll_data: got %h expected 80000000", out_data); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL sll_zero: got %b expected 0", out_zero); end
    $display("sll 1<<31: out_data=%h out_zero=%b", out_data, out_zero);
    step();
    clear_queues();
  endtask

  task automatic test_ops();
    logic [1:0]  ops[4]  = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [31:0] want[4] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h80000000; in_shamt = 5'd4; in_op = ops[i];
      step();
    end
    drain();
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL ops_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL ops_data op=%b: got %h expected %h", ops[i], got_q[i], want[i]); end
      n_checks++; if (gotz_q[i] !== (want[i] == 0)) begin n_fail++; $display("FAIL ops_zero op=%b: got %b expected %b", ops[i], gotz_q[i], want[i] == 0); end
      $display("op=%b 80000000 by 4: out_data=%h", ops[i], got_q[i]);
    end
    clear_queues();
  endtask

  task automatic test_boundary();
    logic [31:0] ops_data[5];
    logic [1:0]  ops[5]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ops_data[i] = (i == 4) ? 32'hFFFFFFFF : ($urandom | 32'h80000001);
      in_valid = 1'b1; in_data = ops_data[i]; in_op = ops[i];
      in_shamt = (i == 4) ? 5'd31 : 5'd0;
      step();
    end
    drain();
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL boundary_count: got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== ops_data[i]) begin n_fail++; $display("FAIL boundary_data %0d: got %h expected %h", i, got_q[i], ops_data[i]); end
      $display("boundary %0d op=%b: out_data=%h", i, ops[i], got_q[i]);
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      if (c < 4) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        n_out++;
        if (first < 0) first = c;
        last = c;
      end
      step();
    end
    n_checks++; if (n_out != 4 || last - first != 3) begin n_fail++; $display("FAIL stream_spacing: got %0d results over %0d cycles expected 4 over 4", n_out, last - first + 1); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_data %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    $display("stream: %0d results, first at cycle %0d", n_out, first);
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [31:0] held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      step();
      if (c == 1) held = out_data;
      if (c >= 2) begin
        n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_hold c=%0d: got %h expected %h", c, out_data, held); end
      end
    end
    n_checks++; if (exp_q.size() != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", exp_q.size()); end
    #1;
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full: got ready=%b busy=%b valid=%b expected 0/1/1", in_ready, busy, out_valid); end
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    $display("backpressure: accepted %0d, drained %0d", exp_q.size(), got_q.size());
    clear_queues();
  endtask

  task automatic test_reset_mid();
    int leaked = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = 5'd0; in_op = 2'b10;
      step();
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b1) begin
      n_fail++; $display("FAIL midreset_state: got valid=%b busy=%b ready=%b zero=%b expected 0/0/1/1", out_valid, busy, in_ready, out_zero);
    end
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b0) leaked++;
      step();
    end
    n_checks++; if (leaked != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL midreset_leak: got %0d valid cycles expected 0", leaked + got_q.size()); end
    $display("mid-reset: leaked=%0d", leaked);
    clear_queues();
  endtask

  task automatic test_random();
    logic        hold;
    logic [31:0] prev;
    int          unstable = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = $urandom;
      in_shamt  = 5'($urandom);
      in_op     = 2'($urandom);
      #1;
      hold = out_valid && !out_ready;
      prev = out_data;
      step();
      if (hold && (out_valid !== 1'b1 || out_data !== prev)) unstable++;
    end
    drain();
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL random_stall_stable: got %0d changes expected 0", unstable); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_data %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      n_checks++; if (gotz_q[i] !== (exp_q[i] == 0)) begin n_fail++; $display("FAIL random_zero %0d: got %b expected %b", i, gotz_q[i], exp_q[i] == 0); end
    end
    $display("random: %0d requests scored", got_q.size());
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_sll_latency();
    test_ops();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
